ysyx_041461_pipe_ctrl: RTL and testbench

Central pipeline hazard/flush controller. It drives the enable and bubble (flush) inputs of the IF→ID, ID→EXE, EXE→MEM and MEM→WB stage registers and the PC update port.
It arbitrates stall requests (fetch, load/store, multi-cycle EXE, load-use) and redirect requests (EXE branch/jump, WB trap/mret). A small FSM defers redirects that arrive while a fetch is outstanding.

---
 rtl/ysyx_041461_pipe_ctrl.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_ysyx_041461_pipe_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_041461_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_041461_pipe_ctrl
// Central pipeline hazard / flush controller. Drives the capture enables and
// bubble (flush) controls of the IF->ID, ID->EXE, EXE->MEM and MEM->WB stage
// registers, plus the PC enable and the PC redirect port.
//
// Stall sources (highest priority first): lsu_busy, exe_busy, load-use,
// ifu_busy. Redirect sources: WB trap/mret (trap_req) beats EXE branch/jump
// (redirect_req). A redirect or trap accepted while a fetch is outstanding
// is parked in REDIR_WAIT until the fetch returns. The returning fetch is
// wrong-path, so it is bubbled.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   ifu_busy/lsu_busy/exe_busy  stall requests from IF / MEM / EXE
//   id_* , exe_*                operand / destination info for load-use
//   redirect_req/redirect_pc    EXE redirect (level, held until acked)
//   trap_req/trap_pc            WB trap/mret redirect (level, held until acked)
//   pc_enable, *reg_enable      PC and stage register capture enables
//   *reg_flush                  insert a bubble into that stage register
//   pc_redirect_valid/target    load target into the PC this cycle
//   redirect_ack, trap_ack      request accepted this cycle
//   cnt_*                       performance counters
//
// Optional feature: define YSYX_041461_PIPE_PERF_EN to build the performance
// counters. Without it, the counter outputs are constant zero and no counter
// flops exist.
// ---------------------------------------------------------------------------
module ysyx_041461_pipe_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifu_busy,
  input  logic             lsu_busy,
  input  logic             exe_busy,
  input  logic             id_valid,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             exe_valid,
  input  logic             exe_is_load,
  input  logic [4:0]       exe_rd,
  input  logic             redirect_req,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             trap_req,
  input  logic [XLEN-1:0]  trap_pc,
  output logic             pc_enable,
  output logic             IDreg_enable,
  output logic             EXEreg_enable,
  output logic             MEMreg_enable,
  output logic             WBreg_enable,
  output logic             IDreg_flush,
  output logic             EXEreg_flush,
  output logic             MEMreg_flush,
  output logic             WBreg_flush,
  output logic             pc_redirect_valid,
  output logic [XLEN-1:0]  pc_redirect_target,
  output logic             redirect_ack,
  output logic             trap_ack,
  output logic [CNT_W-1:0] cnt_stall_mem,
  output logic [CNT_W-1:0] cnt_stall_exe,
  output logic [CNT_W-1:0] cnt_load_use,
  output logic [CNT_W-1:0] cnt_flush
);

  typedef enum logic [0:0] {
    ST_RUN        = 1'b0,
    ST_REDIR_WAIT = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [XLEN-1:0]   tgt_r;
  logic [XLEN-1:0]   tgt_nxt_s;

  logic              load_use_s;
  logic              trap_acc_s;
  logic              redir_acc_s;
  logic [XLEN-1:0]   acc_tgt_s;

  logic              pc_en_s;
  logic              id_en_s, exe_en_s, mem_en_s, wb_en_s;
  logic              id_fl_s, exe_fl_s, mem_fl_s, wb_fl_s;
  logic              rv_s;
  logic [XLEN-1:0]   tgt_s;

  // Load in EXE whose destination is read by the instruction in ID. x0 never
  // creates a dependency.
  assign load_use_s = exe_valid & exe_is_load & (exe_rd != 5'd0) & id_valid &
                      ((id_rs1_used & (id_rs1 == exe_rd)) |
                       (id_rs2_used & (id_rs2 == exe_rd)));

  // A trap needs MEM to be quiet. A branch redirect additionally needs EXE to
  // be done and loses to a trap. It is never taken while a redirect is parked.
  assign trap_acc_s  = trap_req & ~lsu_busy & ~rst;
  assign redir_acc_s = redirect_req & ~trap_acc_s & ~lsu_busy & ~exe_busy &
                       (state_r == ST_RUN) & ~rst;
  assign acc_tgt_s   = trap_acc_s ? trap_pc : redirect_pc;

  // Stall arbitration, redirect handling and next-state selection.
  always_comb begin
    pc_en_s     = 1'b1;
    id_en_s     = 1'b1;
    exe_en_s    = 1'b1;
    mem_en_s    = 1'b1;
    wb_en_s     = 1'b1;
    id_fl_s     = 1'b0;
    exe_fl_s    = 1'b0;
    mem_fl_s    = 1'b0;
    wb_fl_s     = 1'b0;
    rv_s        = 1'b0;
    tgt_s       = {XLEN{1'b0}};
    state_nxt_s = state_r;
    tgt_nxt_s   = tgt_r;

    // Freeze everything upstream of the stalling stage and bubble the stage
    // just downstream of it.
    if (lsu_busy) begin
      pc_en_s  = 1'b0;
      id_en_s  = 1'b0;
      exe_en_s = 1'b0;
      mem_en_s = 1'b0;
      wb_fl_s  = 1'b1;
    end else if (exe_busy) begin
      pc_en_s  = 1'b0;
      id_en_s  = 1'b0;
      exe_en_s = 1'b0;
      mem_fl_s = 1'b1;
    end else if (load_use_s) begin
      pc_en_s  = 1'b0;
      id_en_s  = 1'b0;
      exe_fl_s = 1'b1;
    end else if (ifu_busy) begin
      pc_en_s  = 1'b0;
      id_fl_s  = 1'b1;
    end else begin
      pc_en_s  = 1'b1;
    end

    case (state_r)
      ST_RUN: begin
        if (trap_acc_s | redir_acc_s) begin
          tgt_s = acc_tgt_s;
          if (ifu_busy) begin
            // Cannot steer the PC under an outstanding fetch; park the target.
            pc_en_s     = 1'b0;
            tgt_nxt_s   = acc_tgt_s;
            state_nxt_s = ST_REDIR_WAIT;
          end else begin
            pc_en_s     = 1'b1;
            rv_s        = 1'b1;
          end
        end else begin
          tgt_s = {XLEN{1'b0}};
        end
      end
      ST_REDIR_WAIT: begin
        // The fetch in flight is wrong-path: hold the PC, bubble ID.
        pc_en_s = 1'b0;
        id_fl_s = 1'b1;
        if (trap_acc_s) begin
          tgt_nxt_s = trap_pc;
        end else begin
          tgt_nxt_s = tgt_r;
        end
        if (ifu_busy) begin
          tgt_s = tgt_r;
        end else begin
          rv_s        = 1'b1;
          state_nxt_s = ST_RUN;
          tgt_s       = trap_acc_s ? trap_pc : tgt_r;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase

    if (trap_acc_s) begin
      id_fl_s  = 1'b1;
      exe_fl_s = 1'b1;
      mem_fl_s = 1'b1;
      wb_fl_s  = 1'b1;
    end else begin
      wb_fl_s  = wb_fl_s;
    end

    if (redir_acc_s) begin
      id_fl_s  = 1'b1;
      exe_fl_s = 1'b1;
    end else begin
      exe_fl_s = exe_fl_s;
    end

    // A bubble must actually be captured, so a flush always opens its enable.
    id_en_s  = id_en_s  | id_fl_s;
    exe_en_s = exe_en_s | exe_fl_s;
    mem_en_s = mem_en_s | mem_fl_s;
    wb_en_s  = wb_en_s  | wb_fl_s;

    if (rst) begin
      pc_en_s  = 1'b1;
      id_en_s  = 1'b1;
      exe_en_s = 1'b1;
      mem_en_s = 1'b1;
      wb_en_s  = 1'b1;
      id_fl_s  = 1'b0;
      exe_fl_s = 1'b0;
      mem_fl_s = 1'b0;
      wb_fl_s  = 1'b0;
      rv_s     = 1'b0;
      tgt_s    = {XLEN{1'b0}};
    end else begin
      rv_s     = rv_s;
    end
  end

  // FSM state and parked redirect target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
      tgt_r   <= {XLEN{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      tgt_r   <= tgt_nxt_s;
    end
  end

  assign pc_enable          = pc_en_s;
  assign IDreg_enable       = id_en_s;
  assign EXEreg_enable      = exe_en_s;
  assign MEMreg_enable      = mem_en_s;
  assign WBreg_enable       = wb_en_s;
  assign IDreg_flush        = id_fl_s;
  assign EXEreg_flush       = exe_fl_s;
  assign MEMreg_flush       = mem_fl_s;
  assign WBreg_flush        = wb_fl_s;
  assign pc_redirect_valid  = rv_s;
  assign pc_redirect_target = tgt_s;
  assign redirect_ack       = redir_acc_s;
  assign trap_ack           = trap_acc_s;

`ifdef YSYX_041461_PIPE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_mem_r, cnt_exe_r, cnt_lu_r, cnt_fl_r;
  logic             exe_win_s, lu_win_s;

  assign exe_win_s = ~lsu_busy & exe_busy;
  assign lu_win_s  = ~lsu_busy & ~exe_busy & load_use_s;

  // Event counters; they wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_mem_r <= {CNT_W{1'b0}};
      cnt_exe_r <= {CNT_W{1'b0}};
      cnt_lu_r  <= {CNT_W{1'b0}};
      cnt_fl_r  <= {CNT_W{1'b0}};
    end else begin
      cnt_mem_r <= lsu_busy                    ? cnt_mem_r + CNT_ONE : cnt_mem_r;
      cnt_exe_r <= exe_win_s                   ? cnt_exe_r + CNT_ONE : cnt_exe_r;
      cnt_lu_r  <= lu_win_s                    ? cnt_lu_r  + CNT_ONE : cnt_lu_r;
      cnt_fl_r  <= (trap_acc_s | redir_acc_s)  ? cnt_fl_r  + CNT_ONE : cnt_fl_r;
    end
  end

  assign cnt_stall_mem = cnt_mem_r;
  assign cnt_stall_exe = cnt_exe_r;
  assign cnt_load_use  = cnt_lu_r;
  assign cnt_flush     = cnt_fl_r;
`else
  assign cnt_stall_mem = {CNT_W{1'b0}};
  assign cnt_stall_exe = {CNT_W{1'b0}};
  assign cnt_load_use  = {CNT_W{1'b0}};
  assign cnt_flush     = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ysyx_041461_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ysyx_041461_pipe_ctrl. A behavioural model computes
// the expected outputs from the stall depth and the redirect rules. Outputs
// are compared every negative clock edge, and directed vectors carry
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_ysyx_041461_pipe_ctrl;

  typedef struct packed {
    logic        ifu, lsu, exe, idv, r1u, r2u;
    logic [4:0]  rs1, rs2;
    logic        exv, exl;
    logic [4:0]  rd;
    logic        rreq;
    logic [63:0] rpc;
    logic        treq;
    logic [63:0] tpc;
  } stim_t;

  typedef struct packed {
    logic [4:0]  en;      // 0=pc 1=ID 2=EXE 3=MEM 4=WB
    logic [4:1]  fl;      // 1=ID 2=EXE 3=MEM 4=WB
    logic        rv;
    logic [63:0] tgt;
    logic        rack, tack;
    logic [2:0]  depth;
    logic        nwait;
    logic [63:0] ntgt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  stim_t       s;

  logic        pc_enable, IDreg_enable, EXEreg_enable, MEMreg_enable, WBreg_enable;
  logic        IDreg_flush, EXEreg_flush, MEMreg_flush, WBreg_flush;
  logic        pc_redirect_valid, redirect_ack, trap_ack;
  logic [63:0] pc_redirect_target;
  logic [31:0] cnt_stall_mem, cnt_stall_exe, cnt_load_use, cnt_flush;

  int n_tests = 0;
  int n_fail  = 0;

  logic        m_wait;
  logic [63:0] m_tgt;
  logic [31:0] m_cmem, m_cexe, m_clu, m_cfl;
  exp_t        cur_e;

  always #5 clk = ~clk;

  ysyx_041461_pipe_ctrl #(.XLEN(64), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_busy(s.ifu), .lsu_busy(s.lsu), .exe_busy(s.exe),
    .id_valid(s.idv), .id_rs1_used(s.r1u), .id_rs2_used(s.r2u),
    .id_rs1(s.rs1), .id_rs2(s.rs2),
    .exe_valid(s.exv), .exe_is_load(s.exl), .exe_rd(s.rd),
    .redirect_req(s.rreq), .redirect_pc(s.rpc),
    .trap_req(s.treq), .trap_pc(s.tpc),
    .pc_enable(pc_enable),
    .IDreg_enable(IDreg_enable), .EXEreg_enable(EXEreg_enable),
    .MEMreg_enable(MEMreg_enable), .WBreg_enable(WBreg_enable),
    .IDreg_flush(IDreg_flush), .EXEreg_flush(EXEreg_flush),
    .MEMreg_flush(MEMreg_flush), .WBreg_flush(WBreg_flush),
    .pc_redirect_valid(pc_redirect_valid), .pc_redirect_target(pc_redirect_target),
    .redirect_ack(redirect_ack), .trap_ack(trap_ack),
    .cnt_stall_mem(cnt_stall_mem), .cnt_stall_exe(cnt_stall_exe),
    .cnt_load_use(cnt_load_use), .cnt_flush(cnt_flush)
  );

  // Stall depth = number of front stages (pc, ID, EXE, MEM) frozen; the bubble
  // goes into the register at that depth. Redirects then overlay flushes.
  function automatic exp_t model(input stim_t i, input logic r, input logic w,
                                 input logic [63:0] t);
    exp_t e;
    int   d;
    logic lu;
    lu = i.exv & i.exl & (i.rd != 5'd0) & i.idv &
         ((i.r1u & (i.rs1 == i.rd)) | (i.r2u & (i.rs2 == i.rd)));
    d = i.lsu ? 4 : i.exe ? 3 : lu ? 2 : i.ifu ? 1 : 0;
    e = '0;
    for (int k = 0; k < 5; k++) e.en[k] = (k >= d);
    if (d != 0) e.fl[d] = 1'b1;
    e.depth = 3'(d);
    e.tack  = i.treq & !i.lsu;
    e.rack  = i.rreq & !e.tack & !i.lsu & !i.exe & !w;
    if (e.tack) e.fl = 4'b1111;
    if (e.rack) begin e.fl[1] = 1'b1; e.fl[2] = 1'b1; end
    if (w) e.fl[1] = 1'b1;
    if (w) e.en[0] = 1'b0;
    else if (e.tack | e.rack) e.en[0] = !i.ifu;
    e.rv  = w ? !i.ifu : ((e.tack | e.rack) & !i.ifu);
    e.tgt = e.tack ? i.tpc : (w ? t : i.rpc);
    for (int k = 1; k < 5; k++) e.en[k] = e.en[k] | e.fl[k];
    e.nwait = i.ifu & (w | e.tack | e.rack);
    e.ntgt  = e.tack ? i.tpc : (e.rack ? i.rpc : t);
    if (r) begin
      e.en = 5'b11111; e.fl = 4'b0000; e.rv = 1'b0; e.tgt = 64'd0;
      e.rack = 1'b0; e.tack = 1'b0;
    end
    return e;
  endfunction

  always_comb cur_e = model(s, rst, m_wait, m_tgt);

  // Model state and counters.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wait <= 1'b0; m_tgt <= 64'd0;
      m_cmem <= 32'd0; m_cexe <= 32'd0; m_clu <= 32'd0; m_cfl <= 32'd0;
    end else begin
      m_wait <= cur_e.nwait;
      m_tgt  <= cur_e.ntgt;
      m_cmem <= m_cmem + (s.lsu ? 32'd1 : 32'd0);
      m_cexe <= m_cexe + ((cur_e.depth == 3'd3) ? 32'd1 : 32'd0);
      m_clu  <= m_clu  + ((cur_e.depth == 3'd2) ? 32'd1 : 32'd0);
      m_cfl  <= m_cfl  + ((cur_e.tack | cur_e.rack) ? 32'd1 : 32'd0);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cmp_pc_en",   pc_enable,     cur_e.en[0]);
    chk("cmp_id_en",   IDreg_enable,  cur_e.en[1]);
    chk("cmp_exe_en",  EXEreg_enable, cur_e.en[2]);
    chk("cmp_mem_en",  MEMreg_enable, cur_e.en[3]);
    chk("cmp_wb_en",   WBreg_enable,  cur_e.en[4]);
    chk("cmp_id_fl",   IDreg_flush,   cur_e.fl[1]);
    chk("cmp_exe_fl",  EXEreg_flush,  cur_e.fl[2]);
    chk("cmp_mem_fl",  MEMreg_flush,  cur_e.fl[3]);
    chk("cmp_wb_fl",   WBreg_flush,   cur_e.fl[4]);
    chk("cmp_rv",      pc_redirect_valid, cur_e.rv);
    chk("cmp_rack",    redirect_ack,  cur_e.rack);
    chk("cmp_tack",    trap_ack,      cur_e.tack);
    if (cur_e.rv | rst) chk("cmp_tgt", pc_redirect_target, cur_e.tgt);
`ifdef YSYX_041461_PIPE_PERF_EN
    chk("cmp_cnt_mem", cnt_stall_mem, m_cmem);
    chk("cmp_cnt_exe", cnt_stall_exe, m_cexe);
    chk("cmp_cnt_lu",  cnt_load_use,  m_clu);
    chk("cmp_cnt_fl",  cnt_flush,     m_cfl);
`else
    chk("cmp_cnt_mem", cnt_stall_mem, 64'd0);
    chk("cmp_cnt_exe", cnt_stall_exe, 64'd0);
    chk("cmp_cnt_lu",  cnt_load_use,  64'd0);
    chk("cmp_cnt_fl",  cnt_flush,     64'd0);
`endif
  end

  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b0;
    s   = '0;
    #1 rst = 1'b1;
    next_cyc();
    // Requests during reset must be ignored.
    s.lsu = 1'b1; s.rreq = 1'b1; s.rpc = 64'h8000_0100; s.treq = 1'b1; s.tpc = 64'h8000_0004;
    settle();
    chk("rst_pc_en",  pc_enable, 64'd1);
    chk("rst_mem_en", MEMreg_enable, 64'd1);
    chk("rst_wb_fl",  WBreg_flush, 64'd0);
    chk("rst_rv",     pc_redirect_valid, 64'd0);
    chk("rst_tgt",    pc_redirect_target, 64'd0);
    chk("rst_tack",   trap_ack, 64'd0);
    chk("rst_cnt",    cnt_stall_mem, 64'd0);
    next_cyc();
    s = '0; rst = 1'b0;

    // Load-use on rs1.
    next_cyc();
    s.idv = 1'b1; s.r1u = 1'b1; s.rs1 = 5'd5; s.exv = 1'b1; s.exl = 1'b1; s.rd = 5'd5;
    settle();
    chk("lu_pc_en",   pc_enable, 64'd0);
    chk("lu_id_en",   IDreg_enable, 64'd0);
    chk("lu_exe_fl",  EXEreg_flush, 64'd1);
    chk("lu_exe_en",  EXEreg_enable, 64'd1);
    chk("lu_mem_en",  MEMreg_enable, 64'd1);
    next_cyc();
    s.rd = 5'd0;
    settle();
    chk("lu0_pc_en",  pc_enable, 64'd1);
    chk("lu0_exe_fl", EXEreg_flush, 64'd0);
    // Load-use on rs2.
    next_cyc();
    s.rd = 5'd7; s.r2u = 1'b1; s.rs2 = 5'd7;
    settle();
    chk("lu2_id_en",  IDreg_enable, 64'd0);
    next_cyc();
    s = '0;

    // lsu_busy and exe_busy together for 3 cycles.
    for (int c = 0; c < 3; c++) begin
      next_cyc();
      s.lsu = 1'b1; s.exe = 1'b1;
      settle();
      chk("lsu_pc_en",  pc_enable, 64'd0);
      chk("lsu_exe_en", EXEreg_enable, 64'd0);
      chk("lsu_mem_en", MEMreg_enable, 64'd0);
      chk("lsu_wb_fl",  WBreg_flush, 64'd1);
      chk("lsu_mem_fl", MEMreg_flush, 64'd0);
    end
    next_cyc();
    s.lsu = 1'b0; s.exe = 1'b0;
    settle();
`ifdef YSYX_041461_PIPE_PERF_EN
    chk("perf_mem", cnt_stall_mem, 64'd3);
    chk("perf_exe", cnt_stall_exe, 64'd0);
    chk("perf_lu",  cnt_load_use,  64'd2);
`else
    chk("perf_off", cnt_stall_mem, 64'd0);
`endif
    // exe_busy alone.
    next_cyc();
    s.exe = 1'b1;
    settle();
    chk("exe_mem_fl", MEMreg_flush, 64'd1);
    chk("exe_exe_en", EXEreg_enable, 64'd0);
    chk("exe_wb_fl",  WBreg_flush, 64'd0);
    next_cyc();
    s = '0;

    // Redirect with no fetch outstanding.
    s.rreq = 1'b1; s.rpc = 64'h8000_0100;
    settle();
    chk("rd_rv",     pc_redirect_valid, 64'd1);
    chk("rd_tgt",    pc_redirect_target, 64'h8000_0100);
    chk("rd_ack",    redirect_ack, 64'd1);
    chk("rd_id_fl",  IDreg_flush, 64'd1);
    chk("rd_exe_fl", EXEreg_flush, 64'd1);
    chk("rd_mem_fl", MEMreg_flush, 64'd0);

    // Redirect under an outstanding fetch.
    next_cyc();
    s.ifu = 1'b1;
    settle();
    chk("rw_ack",   redirect_ack, 64'd1);
    chk("rw_rv",    pc_redirect_valid, 64'd0);
    chk("rw_pc_en", pc_enable, 64'd0);
    next_cyc();
    s.rreq = 1'b0;
    settle();
    chk("rw1_id_fl", IDreg_flush, 64'd1);
    chk("rw1_rv",    pc_redirect_valid, 64'd0);
    next_cyc();
    s.rreq = 1'b1; s.rpc = 64'hDEAD_0000;
    settle();
    chk("rw2_noack", redirect_ack, 64'd0);
    chk("rw2_id_fl", IDreg_flush, 64'd1);
    next_cyc();
    s.rreq = 1'b0; s.ifu = 1'b0;
    settle();
    chk("rw3_rv",  pc_redirect_valid, 64'd1);
    chk("rw3_tgt", pc_redirect_target, 64'h8000_0100);
    next_cyc();
    settle();
    chk("rw4_rv",    pc_redirect_valid, 64'd0);
    chk("rw4_id_fl", IDreg_flush, 64'd0);
    chk("rw4_pc_en", pc_enable, 64'd1);

    // Trap overwrites a parked redirect.
    next_cyc();
    s.rreq = 1'b1; s.rpc = 64'h8000_0200; s.ifu = 1'b1;
    settle();
    chk("tw_rack", redirect_ack, 64'd1);
    next_cyc();
    s.rreq = 1'b0; s.treq = 1'b1; s.tpc = 64'h8000_0004;
    settle();
    chk("tw_tack",   trap_ack, 64'd1);
    chk("tw_id_fl",  IDreg_flush, 64'd1);
    chk("tw_exe_fl", EXEreg_flush, 64'd1);
    chk("tw_mem_fl", MEMreg_flush, 64'd1);
    chk("tw_wb_fl",  WBreg_flush, 64'd1);
    next_cyc();
    s.treq = 1'b0;
    settle();
    chk("tw1_rv", pc_redirect_valid, 64'd0);
    next_cyc();
    s.ifu = 1'b0;
    settle();
    chk("tw2_rv",  pc_redirect_valid, 64'd1);
    chk("tw2_tgt", pc_redirect_target, 64'h8000_0004);
    next_cyc();
    s = '0;

    // Both requests blocked by lsu_busy, then trap wins.
    s.rreq = 1'b1; s.rpc = 64'h8000_0300; s.treq = 1'b1; s.tpc = 64'h8000_0008; s.lsu = 1'b1;
    settle();
    chk("bl_tack", trap_ack, 64'd0);
    chk("bl_rack", redirect_ack, 64'd0);
    chk("bl_rv",   pc_redirect_valid, 64'd0);
    next_cyc();
    s.lsu = 1'b0;
    settle();
    chk("bl1_tack", trap_ack, 64'd1);
    chk("bl1_rack", redirect_ack, 64'd0);
    chk("bl1_tgt",  pc_redirect_target, 64'h8000_0008);
    chk("bl1_wb_fl", WBreg_flush, 64'd1);
    next_cyc();
    s.treq = 1'b0;
    settle();
    chk("bl2_rack", redirect_ack, 64'd1);
    chk("bl2_tgt",  pc_redirect_target, 64'h8000_0300);
    next_cyc();
    s = '0;

    // Trap overrides an EXE stall.
    s.exe = 1'b1; s.treq = 1'b1; s.tpc = 64'h8000_0010;
    settle();
    chk("tx_tack",   trap_ack, 64'd1);
    chk("tx_pc_en",  pc_enable, 64'd1);
    chk("tx_exe_en", EXEreg_enable, 64'd1);
    chk("tx_rv",     pc_redirect_valid, 64'd1);
    next_cyc();
    s = '0;

    // Reset in the middle of a parked redirect.
    s.rreq = 1'b1; s.rpc = 64'h8000_0400; s.ifu = 1'b1;
    settle();
    chk("rr_rack", redirect_ack, 64'd1);
    next_cyc();
    s.rreq = 1'b0;
    settle();
    chk("rr_id_fl", IDreg_flush, 64'd1);
    next_cyc();
    rst = 1'b1;
    settle();
    chk("rr_rst_rv",    pc_redirect_valid, 64'd0);
    chk("rr_rst_id_fl", IDreg_flush, 64'd0);
    chk("rr_rst_cnt",   cnt_flush, 64'd0);
    chk("rr_rst_cntm",  cnt_stall_mem, 64'd0);
    next_cyc();
    rst = 1'b0; s.ifu = 1'b0;
    settle();
    chk("rr_run_rv",    pc_redirect_valid, 64'd0);
    chk("rr_run_pc_en", pc_enable, 64'd1);
    next_cyc();
    next_cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
